timer_bank: RTL and testbench

//  Multi-channel successor to the single FPG8 countdown timer; bank of CHANNELS independent down-counters loaded from the 16-bit bus.

---
 rtl/timer_bank.sv | 134 +++++++++++++
 tb/tb_timer_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// timer_bank: a bank of CHANNELS independent down-counters that share one prescaler.
//
// Each channel has its own state:
//   - a count and a reload value, both loaded from DATA;
//   - a control pair {auto_reload, enable};
//   - a sticky timeout flag.
// The per-channel flags and their OR go to the control unit for preemption and
// interrupt sequencing. CHANNELS=1, PRESCALE=1, RESET_CTRL=2'b01 behaves like the
// original single countdown timer.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   reset          synchronous, active-high
//   DATA           bus value for a count load or a ctrl write
//   timer_in       load count and reload of the selected channel from DATA
//   ctrl_in        write {auto_reload, enable} = DATA[1:0] of the selected channel
//   timeout_ack    clear the sticky timeout of the selected channel
//   timer_sel      channel index for timer_in / ctrl_in / timeout_ack
//   REG_OUT_TIMER  current counts; channel i is at [i*WIDTH +: WIDTH]
//   timeout        sticky per-channel expiry flags
//   timeout_any    OR of timeout
module timer_bank #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned PRESCALE   = 1,
  parameter logic [1:0]  RESET_CTRL = 2'b01
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          DATA,
  input  logic                      timer_in,
  input  logic                      ctrl_in,
  input  logic                      timeout_ack,
  input  logic [SEL_W-1:0]          timer_sel,
  output logic [CHANNELS*WIDTH-1:0] REG_OUT_TIMER,
  output logic [CHANNELS-1:0]       timeout,
  output logic                      timeout_any
);

  localparam int unsigned    PsW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsMax = PsW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

  // Prescaler. It runs freely from 0 to PRESCALE-1 and raises tick on the last value.
  logic [PsW-1:0] presc_q, presc_d;
  logic           tick;

  always_comb begin
    tick    = (presc_q == PsMax);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  // Per-channel state.
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [WIDTH-1:0]    reload_q [CHANNELS];
  logic [WIDTH-1:0]    reload_d [CHANNELS];
  logic [1:0]          ctrl_q   [CHANNELS];  // {auto_reload, enable}
  logic [1:0]          ctrl_d   [CHANNELS];
  logic [CHANNELS-1:0] tmo_q, tmo_d;
  logic [CHANNELS-1:0] sel_hit;

  // An index of CHANNELS or above matches no channel, so such writes and acks do nothing.
  always_comb begin
    sel_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      sel_hit[i] = (32'(timer_sel) == i);
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      ctrl_d[i]   = ctrl_q[i];

      if (sel_hit[i] && ctrl_in) begin
        ctrl_d[i] = DATA[1:0];
      end

      // Apply the ack first, so that an expiry or a zero-load on the same edge
      // overrides it and leaves the flag set.
      if (sel_hit[i] && timeout_ack) begin
        tmo_d[i] = 1'b0;
      end

      if (sel_hit[i] && timer_in) begin
        count_d[i]  = DATA;
        reload_d[i] = DATA;
        tmo_d[i]    = (DATA == '0);
      end else if (tick && ctrl_q[i][0]) begin
        if (count_q[i] > CountOne) begin
          count_d[i] = count_q[i] - CountOne;
        end else if (count_q[i] == CountOne) begin
          tmo_d[i]   = 1'b1;
          count_d[i] = ctrl_q[i][1] ? reload_q[i] : '0;
        end
        // A count of zero holds. It never wraps.
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tmo_q   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        ctrl_q[i]   <= RESET_CTRL;
      end
    end else begin
      presc_q <= presc_d;
      tmo_q   <= tmo_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
        ctrl_q[i]   <= ctrl_d[i];
      end
    end
  end

  always_comb begin
    REG_OUT_TIMER = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      REG_OUT_TIMER[i*WIDTH +: WIDTH] = count_q[i];
    end
    timeout     = tmo_q;
    timeout_any = |tmo_q;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Testbench for timer_bank.
// The main instance has 4 channels and a prescaler of 2. A behavioural model follows it and
// is compared against it on every cycle. A second instance uses the legacy configuration
// (1 channel, prescaler 1). Both instances also get hand-computed literal checks.
module tb_timer_bank;
  localparam int CH = 4;
  localparam int PS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance.
  logic        reset, timer_in, ctrl_in, ack;
  logic [15:0] data;
  logic [2:0]  sel;
  logic [63:0] reg_out;
  logic [3:0]  tmo;
  logic        tmo_any;

  timer_bank #(
    .WIDTH(16), .CHANNELS(CH), .SEL_W(3), .PRESCALE(PS), .RESET_CTRL(2'b01)
  ) dut (
    .clk(clk), .reset(reset), .DATA(data), .timer_in(timer_in), .ctrl_in(ctrl_in),
    .timeout_ack(ack), .timer_sel(sel), .REG_OUT_TIMER(reg_out), .timeout(tmo),
    .timeout_any(tmo_any)
  );

  // Legacy instance.
  logic        l_reset, l_tin, l_cin, l_ack;
  logic [0:0]  l_sel;
  logic [15:0] l_data, l_out;
  logic [0:0]  l_tmo;
  logic        l_any;

  timer_bank #(
    .WIDTH(16), .CHANNELS(1), .SEL_W(1), .PRESCALE(1), .RESET_CTRL(2'b01)
  ) dut_leg (
    .clk(clk), .reset(l_reset), .DATA(l_data), .timer_in(l_tin), .ctrl_in(l_cin),
    .timeout_ack(l_ack), .timer_sel(l_sel), .REG_OUT_TIMER(l_out), .timeout(l_tmo),
    .timeout_any(l_any)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state for the main instance.
  int m_cnt [CH];
  int m_rld [CH];
  bit m_en  [CH];
  bit m_ar  [CH];
  bit m_tmo [CH];
  int m_edges;  // rising edges since reset; a tick happens on every PS-th edge

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick;
    bit hit;
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = 0; m_rld[i] = 0; m_en[i] = 1; m_ar[i] = 0; m_tmo[i] = 0;
      end
      m_edges = 0;
    end else begin
      tick = ((m_edges % PS) == PS - 1);
      m_edges++;
      for (int i = 0; i < CH; i++) begin
        hit = (int'(sel) == i);
        if (hit && ack) m_tmo[i] = 0;
        if (hit && timer_in) begin
          m_cnt[i] = int'(data);
          m_rld[i] = int'(data);
          m_tmo[i] = (data == 16'd0);
        end else if (tick && m_en[i]) begin
          if (m_cnt[i] > 1) begin
            m_cnt[i] = m_cnt[i] - 1;
          end else if (m_cnt[i] == 1) begin
            m_tmo[i] = 1;
            m_cnt[i] = m_ar[i] ? m_rld[i] : 0;
          end
        end
        if (hit && ctrl_in) begin
          m_en[i] = data[0];
          m_ar[i] = data[1];
        end
      end
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] exp_t;
      exp_t = '0;
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("model_count%0d", i), 64'(reg_out[i*16 +: 16]), 64'(m_cnt[i]));
        exp_t[i] = m_tmo[i];
      end
      chk("model_timeout", 64'(tmo), 64'(exp_t));
      chk("model_timeout_any", 64'(tmo_any), 64'(|exp_t));
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic op(input bit t, input bit c, input bit a, input logic [2:0] s,
                    input logic [15:0] d);
    timer_in = t; ctrl_in = c; ack = a; sel = s; data = d;
    cyc();
    timer_in = 0; ctrl_in = 0; ack = 0;
  endtask

  initial begin
    reset = 1; timer_in = 0; ctrl_in = 0; ack = 0; sel = 0; data = 0;
    l_reset = 1; l_tin = 0; l_cin = 0; l_ack = 0; l_sel = 0; l_data = 0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("reset_counts", reg_out, 64'd0);
    chk("reset_timeout", 64'(tmo), 64'd0);

    // Legacy behaviour. The main instance stays in reset during this phase.
    l_reset = 0;
    l_data = 16'd3; l_tin = 1; cyc(); l_tin = 0;
    chk("leg_load", 64'(l_out), 64'd3);
    cyc(); chk("leg_c2", 64'(l_out), 64'd2);
    cyc(); chk("leg_c1", 64'(l_out), 64'd1); chk("leg_t_c1", 64'(l_tmo), 64'd0);
    cyc(); chk("leg_c0", 64'(l_out), 64'd0); chk("leg_t_c0", 64'(l_tmo), 64'd1);
    cyc(); chk("leg_hold", 64'(l_out), 64'd0); chk("leg_any", 64'(l_any), 64'd1);
    l_ack = 1; cyc(); l_ack = 0; chk("leg_ack", 64'(l_tmo), 64'd0);
    l_data = 16'd0; l_tin = 1; cyc(); l_tin = 0; chk("leg_zero_load", 64'(l_tmo), 64'd1);

    // Auto-reload on channel 2. Edge 0 after reset is the ctrl write; edge 1 is the load.
    reset = 0;
    op(0, 1, 0, 3'd2, 16'd3);
    op(1, 0, 0, 3'd2, 16'd4);
    chk("ar_load", 64'(reg_out[47:32]), 64'd4);
    idle(7);
    chk("ar_pre_cnt", 64'(reg_out[47:32]), 64'd1);
    chk("ar_pre_t", 64'(tmo[2]), 64'd0);
    idle(1);
    chk("ar_exp_cnt", 64'(reg_out[47:32]), 64'd4);
    chk("ar_exp_t", 64'(tmo[2]), 64'd1);
    op(0, 0, 1, 3'd2, 16'd0);
    chk("ar_ack", 64'(tmo[2]), 64'd0);
    idle(6);
    chk("ar_pre2_t", 64'(tmo[2]), 64'd0);
    idle(1);
    chk("ar_exp2_t", 64'(tmo[2]), 64'd1);
    chk("ar_exp2_cnt", 64'(reg_out[47:32]), 64'd4);

    // Priority on channel 1: expiry beats ack; a nonzero load with ack clears the flag.
    op(1, 0, 0, 3'd1, 16'd2);
    idle(2);
    op(0, 0, 1, 3'd1, 16'd0);
    chk("pri_ack_expiry", 64'(tmo[1]), 64'd1);
    chk("pri_cnt0", 64'(reg_out[31:16]), 64'd0);
    op(1, 0, 1, 3'd1, 16'd5);
    chk("pri_load5_cnt", 64'(reg_out[31:16]), 64'd5);
    chk("pri_load5_t", 64'(tmo[1]), 64'd0);

    // Reset while channel 1 is counting.
    op(1, 0, 0, 3'd1, 16'd7);
    idle(1);
    chk("rst_pre_cnt", 64'(reg_out[31:16]), 64'd7);
    reset = 1; cyc(); reset = 0;
    chk("rst_counts", reg_out, 64'd0);
    chk("rst_timeout", 64'(tmo), 64'd0);

    // Isolation: channel 0 is disabled and frozen; channel 3 expires alone.
    op(0, 1, 0, 3'd0, 16'd0);
    op(1, 0, 0, 3'd0, 16'd10);
    op(1, 0, 0, 3'd3, 16'd2);
    idle(3);
    chk("iso_ch0", 64'(reg_out[15:0]), 64'd10);
    chk("iso_ch3", 64'(reg_out[63:48]), 64'd0);
    chk("iso_timeout", 64'(tmo), 64'b1000);
    chk("iso_any", 64'(tmo_any), 64'd1);

    // Boundaries.
    op(1, 0, 0, 3'd1, 16'd0);
    chk("bnd_zero_load", 64'(tmo), 64'b1010);
    op(1, 0, 0, 3'd2, 16'hFFFF);
    chk("bnd_ffff", 64'(reg_out[47:32]), 64'hFFFF);
    idle(2);
    chk("bnd_ffff_dec", 64'(reg_out[47:32]), 64'hFFFE);
    op(1, 1, 1, 3'd5, 16'h0123);
    op(1, 1, 1, 3'd4, 16'h0003);
    chk("bnd_sel_ch0", 64'(reg_out[15:0]), 64'd10);
    chk("bnd_sel_t", 64'(tmo), 64'b1010);

    // A ctrl write and a load in the same cycle: {auto_reload, enable}=10, count=6, frozen.
    op(1, 1, 0, 3'd0, 16'h0006);
    idle(4);
    chk("both_ch0", 64'(reg_out[15:0]), 64'd6);
    // Enable channel 0 with auto-reload and let the bank run under the model.
    op(0, 1, 0, 3'd0, 16'h0003);
    op(0, 0, 1, 3'd3, 16'd0);
    idle(30);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
